// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: turns one PHY register read/write
// request into a 64-bit MDC/MDIO frame and returns read data with a done pulse.
//
// Ports:
//   i_clk, i_rst     single rising-edge clock, synchronous active-high reset
//   i_phy_addr       REGAD field, sampled with the request
//   i_phy_wr_data    write data ([15:0] used), sampled with the request
//   i_phy_rdwn       1 = read, 0 = write, sampled with the request
//   i_phy_request    one-cycle start pulse, honoured only when idle
//   o_phy_rd_data    {16'h0, read data}, updated at done of a read, held otherwise
//   o_phy_done       one-cycle pulse when a frame completes
//   o_phy_err        valid with done; 1 = read turnaround bit sampled high
//   o_busy           high from the cycle after acceptance through the done cycle
//   o_mdc            registered management clock
//   o_mdio_out       registered MDIO drive value
//   o_mdio_oe        registered MDIO pad output enable
//   i_mdio_in        asynchronous MDIO pad input
module mdio_master #(
    parameter int         CLK_DIV      = 10,
    parameter logic [4:0] PHY_DEV_ADDR = 5'h01
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_phy_addr,
    input  logic [31:0] i_phy_wr_data,
    input  logic        i_phy_rdwn,
    input  logic        i_phy_request,
    output logic [31:0] o_phy_rd_data,
    output logic        o_phy_done,
    output logic        o_phy_err,
    output logic        o_busy,
    output logic        o_mdc,
    output logic        o_mdio_out,
    output logic        o_mdio_oe,
    input  logic        i_mdio_in
);

    localparam int            DW     = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0] L_HALF = DW'(CLK_DIV);
    localparam logic [DW-1:0] L_LAST = DW'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;
    logic [5:0]    r_bit;
    logic [5:0]    w_bit_nxt;
    logic [63:0]   r_frame;
    logic          r_rdwn;
    logic [15:0]   r_rd_sh;
    logic          r_ta;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_mdc;
    logic          r_mdio;
    logic          r_oe;
    logic          r_done;
    logic          r_err;
    logic [15:0]   r_rd_data;

    logic          w_mdc_nxt;
    logic          w_mdio_nxt;
    logic          w_oe_nxt;
    logic          w_load;
    logic          w_sample;
    logic          w_last;
    logic [63:0]   w_frame_new;
    logic          w_unused;

    // Preamble, ST, OP, PHYAD, REGAD, TA, data; read TA/data are don't-care
    // because OE is dropped for those bits.
    assign w_frame_new = {
        32'hFFFF_FFFF,
        2'b01,
        (i_phy_rdwn ? 2'b10 : 2'b01),
        PHY_DEV_ADDR,
        i_phy_addr,
        (i_phy_rdwn ? 2'b00 : 2'b10),
        (i_phy_rdwn ? 16'h0000 : i_phy_wr_data[15:0])
    };

    assign w_unused = ^i_phy_wr_data[31:16];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pad outputs are registered, so the next-cycle values are computed here.
    // MDIO/OE only change when the divider wraps to 0, i.e. at the start
    // of a bit's low phase, keeping them stable across the MDC rising edge.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_mdc_nxt   = 1'b0;
        w_mdio_nxt  = 1'b0;
        w_oe_nxt    = 1'b0;
        w_load      = 1'b0;
        w_sample    = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_phy_request) begin
                    w_state_nxt = S_SHIFT;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_load      = 1'b1;
                    w_mdio_nxt  = w_frame_new[63];
                    w_oe_nxt    = 1'b1;
                end
            end
            S_SHIFT: begin
                w_sample = (r_div == L_LAST);
                if (r_div == L_LAST) begin
                    w_div_nxt = '0;
                    if (r_bit == 6'd63) begin
                        w_state_nxt = S_DONE;
                        w_last      = 1'b1;
                    end else begin
                        w_bit_nxt  = r_bit + 6'd1;
                        w_mdio_nxt = r_frame[62];
                        w_oe_nxt   = r_rdwn ? (w_bit_nxt < 6'd46) : 1'b1;
                    end
                end else begin
                    w_div_nxt  = r_div + DW'(1);
                    w_mdc_nxt  = (w_div_nxt >= L_HALF);
                    w_mdio_nxt = r_mdio;
                    w_oe_nxt   = r_oe;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div     <= '0;
            r_bit     <= '0;
            r_frame   <= '0;
            r_rdwn    <= 1'b0;
            r_rd_sh   <= '0;
            r_ta      <= 1'b0;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_mdc     <= 1'b0;
            r_mdio    <= 1'b0;
            r_oe      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_sync1 <= i_mdio_in;
            r_sync2 <= r_sync1;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_mdc   <= w_mdc_nxt;
            r_mdio  <= w_mdio_nxt;
            r_oe    <= w_oe_nxt;
            r_done  <= w_last;
            if (w_load) begin
                r_frame <= w_frame_new;
                r_rdwn  <= i_phy_rdwn;
            end else if (w_sample && !w_last) begin
                r_frame <= {r_frame[62:0], 1'b0};
            end
            if (w_sample && (r_bit == 6'd47)) begin
                r_ta <= r_sync2;
            end
            if (w_sample && (r_bit >= 6'd48)) begin
                r_rd_sh <= {r_rd_sh[14:0], r_sync2};
            end
            // Bit 63 is sampled on the same edge that enters DONE, so the
            // result takes the live sample rather than the shift register.
            if (w_last) begin
                r_err <= r_rdwn & r_ta;
                if (r_rdwn) begin
                    r_rd_data <= {r_rd_sh[14:0], r_sync2};
                end
            end
        end
    end

    assign o_phy_rd_data = {16'h0000, r_rd_data};
    assign o_phy_done    = r_done;
    assign o_phy_err     = r_err;
    assign o_busy        = (r_state != S_IDLE);
    assign o_mdc         = r_mdc;
    assign o_mdio_out    = r_mdio;
    assign o_mdio_oe     = r_oe;

endmodule
